// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the pipelined MIPS32 core: load-use, taken-branch and mult/div hazards.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  id_muldiv_start,
  input  logic                  id_reads_hilo,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  muldiv_busy,
  output logic                  muldiv_done
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       lu_hazard, md_hazard, accept;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
  assign lu_hazard = ex_mem_read && (ex_rt != '0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign md_hazard = (state == BUSY) && (id_reads_hilo || id_muldiv_start);
  assign accept    = (state == RUN) && id_muldiv_start && !ex_branch_taken && !lu_hazard;

  assign muldiv_busy = (state == BUSY);
  assign muldiv_done = (state == BUSY) && (cnt == 8'd1);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu_hazard || md_hazard) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      RUN: begin
        if (accept) begin
          state_nxt = BUSY;
          cnt_nxt   = CNT_LOAD;
        end
      end
      BUSY: begin
        // An in-flight operation is never aborted by a front-end flush.
        cnt_nxt = cnt - 8'd1;
        if (cnt == 8'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!pc_write && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ifid_flush && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, hand sequences and a randomized
// run against a cycle-level reference model (occupancy tracked as "cycles remaining").
module tb_pipeline_hazard_ctrl;

  localparam int MC = 4;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       start;
    logic       hilo;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       br;
  } in_t;

  typedef struct {
    in_t        i;
    logic [3:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_muldiv_start, id_reads_hilo, ex_mem_read, ex_branch_taken;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, muldiv_busy, muldiv_done;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(MC), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_muldiv_start(id_muldiv_start), .id_reads_hilo(id_reads_hilo),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: cycles of mult/div occupancy still to come, plus perf event tallies.
  int         rem = 0;
  int         m_stall = 0;
  int         m_flush = 0;
  logic [3:0] last_ctl;
  logic       last_busy, last_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t mk(input int rs, input int rt, input bit uses, input bit start,
                             input bit hilo, input bit mread, input int xrt, input bit br);
    in_t v;
    v.rs = 5'(rs); v.rt = 5'(rt); v.uses_rt = uses; v.start = start; v.hilo = hilo;
    v.mem_read = mread; v.ex_rt = 5'(xrt); v.br = br;
    return v;
  endfunction

  function automatic bit model_lu(input in_t v);
    return v.mem_read && (v.ex_rt != 0) &&
           ((v.ex_rt == v.rs) || (v.uses_rt && (v.ex_rt == v.rt)));
  endfunction

  function automatic logic [3:0] model_ctl(input in_t v, input int r);
    bit stall;
    stall = model_lu(v) || ((r > 0) && (v.hilo || v.start));
    if (v.br)  return 4'b1111;
    if (stall) return 4'b0001;
    return 4'b1100;
  endfunction

  // Called just after a rising edge: drives one cycle, checks mid-cycle, advances the model.
  task automatic apply(input in_t v);
    logic [3:0] exp;
    int         nrem;
    id_rs = v.rs; id_rt = v.rt; id_uses_rt = v.uses_rt; id_muldiv_start = v.start;
    id_reads_hilo = v.hilo; ex_mem_read = v.mem_read; ex_rt = v.ex_rt;
    ex_branch_taken = v.br;
    @(negedge clk);
    exp       = model_ctl(v, rem);
    last_ctl  = {pc_write, ifid_write, ifid_flush, idex_bubble};
    last_busy = muldiv_busy;
    last_done = muldiv_done;
    check("ctl", 32'(last_ctl), 32'(exp));
    check("busy", 32'(muldiv_busy), 32'(rem > 0));
    check("done", 32'(muldiv_done), 32'(rem == 1));
`ifdef HAZARD_PERF_EN
    check("perf_stall", perf_stall_cnt, 32'(m_stall));
    check("perf_flush", perf_flush_cnt, 32'(m_flush));
`endif
    if (rem > 0) nrem = rem - 1;
    else if (v.start && !v.br && !model_lu(v)) nrem = MC;
    else nrem = 0;
    if (!exp[3]) m_stall++;
    if (exp[1])  m_flush++;
    @(posedge clk);
    #1;
    rem = nrem;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 32'({pc_write, ifid_write, ifid_flush, idex_bubble}), 32'b0011);
    check({tag, "_busy"}, 32'(muldiv_busy), 32'd0);
    check({tag, "_done"}, 32'(muldiv_done), 32'd0);
`ifdef HAZARD_PERF_EN
    check({tag, "_pstall"}, perf_stall_cnt, 32'd0);
    check({tag, "_pflush"}, perf_flush_cnt, 32'd0);
`endif
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    rem = 0; m_stall = 0; m_flush = 0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[10];
  in_t  idle, mfhi, start_v, lu_v, br_v;
  int   busy_sum;

  initial begin
    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mfhi    = mk(2, 3, 0, 0, 1, 0, 0, 0);
    start_v = mk(4, 5, 1, 1, 0, 0, 0, 0);
    lu_v    = mk(8, 0, 0, 0, 0, 1, 8, 0);
    br_v    = mk(0, 0, 0, 0, 0, 0, 0, 1);

    tbl[0] = '{mk(8, 1, 0, 0, 0, 1, 8, 0), 4'b0001};  // load-use on rs
    tbl[1] = '{mk(0, 1, 0, 0, 0, 1, 0, 0), 4'b1100};  // load to $zero never stalls
    tbl[2] = '{mk(1, 9, 0, 0, 0, 1, 9, 0), 4'b1100};  // rt match but rt unused
    tbl[3] = '{mk(1, 9, 1, 0, 0, 1, 9, 0), 4'b0001};  // rt match and used
    tbl[4] = '{mk(8, 1, 0, 0, 0, 0, 8, 0), 4'b1100};  // not a load
    tbl[5] = '{mk(8, 1, 0, 0, 0, 1, 8, 1), 4'b1111};  // branch beats load-use
    tbl[6] = '{mk(3, 4, 1, 0, 0, 0, 0, 1), 4'b1111};  // branch alone
    tbl[7] = '{mk(7, 6, 1, 0, 0, 1, 8, 0), 4'b1100};  // no register match
    tbl[8] = '{mk(1, 2, 0, 0, 1, 0, 0, 0), 4'b1100};  // mfhi while idle
    tbl[9] = '{mk(0, 0, 1, 0, 0, 1, 0, 0), 4'b1100};  // both fields zero

    reset = 1'b0;
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_muldiv_start = 0; id_reads_hilo = 0; ex_mem_read = 0; ex_branch_taken = 0;
    #2;
    check_reset_outputs("rst");
    release_reset();

    // Perf sequence: three load-use stalls then two taken branches.
    for (int k = 0; k < 3; k++) apply(lu_v);
    for (int k = 0; k < 2; k++) apply(br_v);
    apply(idle);
`ifdef HAZARD_PERF_EN
    check("perf_stall_seq", perf_stall_cnt, 32'd3);
    check("perf_flush_seq", perf_flush_cnt, 32'd2);
`endif

    foreach (tbl[n]) begin
      apply(tbl[n].i);
      check($sformatf("tbl%0d", n), 32'(last_ctl), 32'(tbl[n].exp));
    end

    // Accept, then an mfhi waits through the whole busy window.
    apply(start_v);
    check("accept_ctl", 32'(last_ctl), 32'b1100);
    for (int k = 1; k <= MC; k++) begin
      apply(mfhi);
      check($sformatf("md_busy%0d", k), 32'(last_busy), 32'd1);
      check($sformatf("md_done%0d", k), 32'(last_done), 32'(k == MC));
      check($sformatf("md_stall%0d", k), 32'(last_ctl), 32'b0001);
    end
    apply(mfhi);
    check("mfhi_go", 32'(last_ctl), 32'b1100);
    check("mfhi_go_busy", 32'(last_busy), 32'd0);

    // Second mult/div is held, then accepted in the first non-busy cycle.
    apply(start_v);
    for (int k = 0; k < MC; k++) apply(start_v);
    check("b2b_held", 32'(last_ctl), 32'b0001);
    apply(start_v);
    check("b2b_accept", 32'(last_ctl), 32'b1100);
    apply(idle);
    check("b2b_busy", 32'(last_busy), 32'd1);
    for (int k = 0; k < MC; k++) apply(idle);

    // Branch with load-use and a start: squashed, no accept.
    apply(mk(8, 1, 0, 1, 0, 1, 8, 1));
    check("br_lu_start", 32'(last_ctl), 32'b1111);
    apply(idle);
    check("br_no_accept", 32'(last_busy), 32'd0);

    // Branch during busy does not abort the operation.
    apply(start_v);
    apply(br_v);
    apply(br_v);
    apply(idle);
    apply(idle);
    check("br_busy_done", 32'(last_done), 32'd1);

    // Reset asserted with counter at 2, then a fresh full window.
    apply(start_v);
    apply(idle);
    apply(idle);
    reset = 1'b0;
    #1;
    check_reset_outputs("midrst");
    release_reset();
    apply(start_v);
    busy_sum = 0;
    for (int k = 0; k < MC + 2; k++) begin
      apply(idle);
      busy_sum += int'(last_busy);
    end
    check("post_rst_window", 32'(busy_sum), 32'(MC));

    // Randomized run; small register range makes dependencies frequent.
    for (int k = 0; k < 400; k++) begin
      apply(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), ($urandom_range(0, 5) == 0)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
